// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//
// Multi-cycle 16-bit multiply/divide unit for the EX stage. It produces a 32-bit
// result that the forwarding select stage splits into high and low halves.
//   MUL  (00) signed product         MULU (01) unsigned product
//   DIV  (10) signed {rem, quot}     DIVU (11) unsigned {rem, quot}
// Each operation takes a fixed 17 cycles from the start sample to done:
// 16 iterations in CALC, then one FIX cycle for sign correction.
//
// Configuration macro: MULDIV_DIV_EN
//   defined   - the divide datapath is built in.
//   undefined - divide ops still run the full sequence and pulse done, but
//               return result = 0 and div_by_zero = 0.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request an operation, sampled only while idle
//   op[1:0]      operation select
//   a[15:0]      multiplicand / dividend
//   b[15:0]      multiplier / divisor
//   flush        synchronous abort: back to idle, no done, outputs untouched
//   busy         operation in progress (registered)
//   done         one-cycle pulse, result valid (registered)
//   result[31:0] product, or {remainder, quotient}; held until the next FIX
//   div_by_zero  set together with done when a divide had b = 0
// -----------------------------------------------------------------------------
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [4:0]  cnt;
  logic        div_q;     // operation in flight is a divide
  logic        neg_q;     // product / quotient must be negated in FIX
  logic [15:0] opnd;      // multiplicand magnitude, or divisor magnitude
  logic [31:0] acc;       // mul: {partial sum, multiplier}; div: {rem, quot}

  logic        load, step, finish;
  logic        busy_d;

  // Operand magnitudes; unsigned ops (op[0] = 1) pass operands straight through.
  logic        is_signed;
  logic [15:0] a_mag, b_mag;

  assign is_signed = ~op[0];
  assign a_mag     = (is_signed && a[15]) ? (~a + 16'd1) : a;
  assign b_mag     = (is_signed && b[15]) ? (~b + 16'd1) : b;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
      done  <= finish;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        // flush wins over a simultaneous start
        if (start && !flush) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == 5'd15) state_d = FIX;
        end
      end
      FIX: begin
        // FIX always leaves; a flush only suppresses done and the result update
        state_d = IDLE;
        finish  = !flush;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  // Shift-add: the multiplier sits in acc[15:0] and is consumed from bit 0 while
  // the partial product grows into the top half, shifting right each step.
  logic [16:0] mul_sum;
  logic [31:0] mul_next;

  assign mul_sum  = {1'b0, acc[31:16]} + (acc[0] ? {1'b0, opnd} : 17'd0);
  assign mul_next = {mul_sum, acc[15:1]};

`ifdef MULDIV_DIV_EN
  logic        rneg_q;    // remainder takes the dividend's sign
  logic        dbz_q;     // divisor was zero
  // Restoring division: the dividend sits in acc[15:0] and shifts into the
  // remainder half; a non-negative trial difference sets the quotient bit.
  // The remainder stays below the divisor, so a 17-bit trial is enough and
  // bit 16 of the difference acts as the borrow.
  logic [16:0] div_shift, div_trial;
  logic [31:0] div_next;

  assign div_shift = {acc[31:16], acc[15]};
  assign div_trial = div_shift - {1'b0, opnd};
  assign div_next  = div_trial[16] ? {div_shift[15:0], acc[14:0], 1'b0}
                                   : {div_trial[15:0], acc[14:0], 1'b1};
`endif

  // NOTE: only control and datapath registers are reset here; there is no
  // memory array, so every flop can take the asynchronous reset cheaply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 5'd0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      opnd   <= 16'd0;
      acc    <= 32'd0;
`ifdef MULDIV_DIV_EN
      rneg_q <= 1'b0;
      dbz_q  <= 1'b0;
`endif
    end else if (load) begin
      cnt   <= 5'd0;
      div_q <= op[1];
      neg_q <= is_signed & (a[15] ^ b[15]);
`ifdef MULDIV_DIV_EN
      rneg_q <= is_signed & a[15];
      dbz_q  <= (b == 16'd0);
      if (op[1]) begin
        opnd <= b_mag;
        acc  <= {16'd0, a_mag};
      end else begin
        opnd <= a_mag;
        acc  <= {16'd0, b_mag};
      end
`else
      opnd <= a_mag;
      acc  <= {16'd0, b_mag};
`endif
    end else if (step) begin
      cnt <= cnt + 5'd1;
`ifdef MULDIV_DIV_EN
      acc <= div_q ? div_next : mul_next;
`else
      acc <= mul_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FIX: sign correction and result register
  // ---------------------------------------------------------------------------
  logic [31:0] res_d;
  logic        dbz_d;

`ifdef MULDIV_DIV_EN
  logic [15:0] quot_fix, rem_fix;
  // On divide by zero the loop already leaves |a| in the remainder, and the
  // dividend sign restores a exactly (including 16'h8000); only the quotient
  // needs forcing to all ones.
  assign rem_fix  = rneg_q ? (~acc[31:16] + 16'd1) : acc[31:16];
  assign quot_fix = dbz_q  ? 16'hFFFF
                  : (neg_q ? (~acc[15:0] + 16'd1) : acc[15:0]);
`endif

  always_comb begin
    res_d = neg_q ? (~acc + 32'd1) : acc;
    dbz_d = 1'b0;
    if (div_q) begin
`ifdef MULDIV_DIV_EN
      res_d = {rem_fix, quot_fix};
      dbz_d = dbz_q;
`else
      res_d = 32'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= 32'd0;
      div_by_zero <= 1'b0;
    end else if (finish) begin
      result      <= res_d;
      div_by_zero <= dbz_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//
// Self-checking bench for mul_div_unit. The driver issues operations and pushes
// the expected {result, div_by_zero, start edge} computed by a plain-arithmetic
// reference model; an independent monitor pops an entry whenever done is seen
// and compares value, flag and latency. Directed cases cover the documented
// corner values, ignored start, flush and reset; a random phase follows.
// Divide expectations follow the MULDIV_DIV_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  mul_div_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          e0;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_res = 32'd0;
  logic        last_dbz = 1'b0;
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: direct arithmetic on integers.
  task automatic model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       output logic [31:0] r, output logic d);
    int sx, sy, ux, uy, q, m;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'({16'd0, x});
    uy = int'({16'd0, y});
    r  = 32'd0;
    d  = 1'b0;
    case (o)
      OP_MUL:  r = sx * sy;
      OP_MULU: r = ux * uy;
      default: begin
`ifdef MULDIV_DIV_EN
        if (y == 16'd0) begin
          r = {x, 16'hFFFF};
          d = 1'b1;
        end else begin
          if (o == OP_DIV) begin
            q = sx / sy;   // truncates toward zero
            m = sx % sy;   // sign of dividend
          end else begin
            q = ux / uy;
            m = ux % uy;
          end
          r = {m[15:0], q[15:0]};
        end
`else
        r = 32'd0;
`endif
      end
    endcase
  endtask

  // Monitor: pops and compares on every done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_width", {31'd0, done}, 32'd0);
      if (done) begin
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=done required=no_done (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", result, e.res);
          check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
          check("latency", cyc - e.e0, 32'd17);
        end
      end
      prev_done = done;
    end
  end

  // Wait until the unit is idle and not presenting done (bounded).
  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Issue one operation; returns one cycle after the start sample.
  task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       input bit expect_done);
    logic [31:0] r;
    logic        d;
    wait_idle();
    model(o, x, y, r, d);
    op = o; a = x; b = y; start = 1'b1;
    if (expect_done) sb.push_back('{res: r, dbz: d, e0: cyc + 1});
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;   // operands must have been captured already
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("result_hold", result, last_res);
    check("dbz_hold", {31'd0, div_by_zero}, {31'd0, last_dbz});
    if (expect_done) begin
      last_res = r;
      last_dbz = d;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner values
    issue(OP_MUL,  16'hFFFD, 16'h0007, 1);
    issue(OP_MULU, 16'hFFFF, 16'hFFFF, 1);
    issue(OP_MUL,  16'hFFFF, 16'hFFFF, 1);
    issue(OP_DIV,  16'hFFF9, 16'h0002, 1);
    issue(OP_DIV,  16'h8000, 16'hFFFF, 1);
    issue(OP_DIVU, 16'h0064, 16'h0000, 1);
    issue(OP_MULU, 16'h0002, 16'h0003, 1);
    issue(OP_DIV,  16'h8000, 16'h0000, 1);
    issue(OP_DIV,  16'h0007, 16'hFFFE, 1);
    issue(OP_DIVU, 16'd100,  16'd3,    1);
    issue(OP_MUL,  16'h8000, 16'h8000, 1);

    // start during a busy MUL is ignored
    issue(OP_MUL, 16'h1234, 16'hFF56, 1);
    repeat (3) @(posedge clk);
    #1;
    op = OP_MULU; a = 16'h0011; b = 16'h0022; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_ignored_start", {31'd0, busy}, 32'd1);

    // flush mid-CALC: busy drops next cycle, no done, result untouched
    issue(OP_MULU, 16'h00AB, 16'h00CD, 0);
    repeat (6) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_result", result, last_res);
    repeat (20) @(posedge clk);
    #1;
    check("flush_no_done_busy", {31'd0, busy}, 32'd0);
    check("flush_result_late", result, last_res);

    // flush and start together: nothing starts
    op = OP_MUL; a = 16'd9; b = 16'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);

    // reset mid-CALC: outputs return to reset values at once
    issue(OP_DIVU, 16'h0064, 16'h0000, 1);
    wait_idle();
    issue(OP_MULU, 16'h1111, 16'h2222, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    sb.delete();
    last_res = 32'd0;
    last_dbz = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(OP_MULU, 16'd5, 16'd5, 1);

    // Randomised operations with biased corner operands
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [15:0] rx, ry;
      ro = 2'($urandom_range(0, 3));
      rx = 16'($urandom);
      ry = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ry = 16'h0000;
        1: ry = 16'hFFFF;
        2: rx = 16'h8000;
        3: ry = 16'h0001;
        default: ;
      endcase
      issue(ro, rx, ry, 1);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
